mem_port_arbiter: RTL and testbench

- Shares one cache/memory request port between two requesters: instruction fetch (port I, read-only) and load/store unit (port D, read/write).
- Sits between the fetch stage, the LSU and the single L1 port.
- Picks one request per cycle and tracks every outstanding request in an order-preserving routing FIFO.
- Steers each in-order response beat back to the requester that issued it.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_port_arbiter_route_fifo.sv | 65 ++++++
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/LSU memory port arbiter.
// Optional build macro: FETCH_FLUSH_EN (adds if_flush and stale-response dropping).
package mem_port_arbiter_pkg;
  localparam int XLEN       = 32;
  localparam int MEM_DATA_W = 64;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } req_src_e;

  typedef struct packed {
    logic [XLEN-1:0]         addr;
    logic                    we;
    logic [MEM_DATA_W/8-1:0] be;
    logic [MEM_DATA_W-1:0]   wdata;
  } mem_req_t;
endpackage

// File: rtl/mem_port_arbiter_route_fifo.sv
// Order-preserving routing FIFO: remembers which requester owns each outstanding beat.
// Optional build macro: FETCH_FLUSH_EN (per-entry stale bit behind mark_stale_i).
module arb_route_fifo
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rstn,
  input  logic     push_i,
  input  req_src_e push_src_i,
  input  logic     pop_i,
  input  logic     mark_stale_i,
  output logic     full_o,
  output logic     empty_o,
  output req_src_e head_src_o,
  output logic     head_stale_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_q, rd_q;
  req_src_e      src_q [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) src_q[wr_q[AW-1:0]] <= push_src_i;
  end

  // Extra pointer MSB tells a full ring from an empty one.
  assign empty_o    = (wr_q == rd_q);
  assign full_o     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_src_o = src_q[rd_q[AW-1:0]];

`ifdef FETCH_FLUSH_EN
  logic [DEPTH-1:0] stale_q;

  // Free slots may get marked too; a push always rewrites the bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stale_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mark_stale_i && src_q[i] == SRC_I) stale_q[i] <= 1'b1;
      end
      if (push_i) stale_q[wr_q[AW-1:0]] <= 1'b0;
    end
  end

  assign head_stale_o = stale_q[rd_q[AW-1:0]];
`else
  logic unused_mark;
  assign unused_mark  = mark_stale_i;
  assign head_stale_o = 1'b0;
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one L1 request port between fetch (I) and LSU (D); responses steered in order.
// Optional build macro: FETCH_FLUSH_EN (if_flush port drops responses of flushed fetches).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_OUTST = 4,
  parameter int DATA_W    = 64
) (
  input  logic                clk,
  input  logic                rstn,
`ifdef FETCH_FLUSH_EN
  input  logic                if_flush,
`endif
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [XLEN-1:0]     if_req_addr,
  output logic                if_rsp_valid,
  input  logic                if_rsp_ready,
  output logic [31:0]         if_rsp_data,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [XLEN-1:0]     d_req_addr,
  input  logic                d_req_we,
  input  logic [DATA_W/8-1:0] d_req_be,
  input  logic [DATA_W-1:0]   d_req_wdata,
  output logic                d_rsp_valid,
  input  logic                d_rsp_ready,
  output logic [DATA_W-1:0]   d_rsp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [XLEN-1:0]     mem_req_addr,
  output logic                mem_req_we,
  output logic [DATA_W/8-1:0] mem_req_be,
  output logic [DATA_W-1:0]   mem_req_wdata,
  input  logic                mem_rsp_valid,
  output logic                mem_rsp_ready,
  input  logic [DATA_W-1:0]   mem_rsp_data
);
  if (DATA_W != MEM_DATA_W) begin : g_bad_width
    $error("mem_port_arbiter: DATA_W must equal mem_port_arbiter_pkg::MEM_DATA_W");
  end

  req_src_e gnt, rr_q, rr_d, lock_src_q, lock_src_d, head_src;
  logic     lock_q, lock_d;
  logic     fifo_full, fifo_empty, head_stale;
  logic     gnt_vld, req_hs, rsp_hs, flush;
  mem_req_t req_mux;

`ifdef FETCH_FLUSH_EN
  assign flush = if_flush;
`else
  assign flush = 1'b0;
`endif

  // rr_q holds the last winner; on a tie the other side wins.
  always_comb begin
    gnt = SRC_I;
    if (lock_q)                           gnt = lock_src_q;
    else if (if_req_valid && d_req_valid) gnt = (rr_q == SRC_I) ? SRC_D : SRC_I;
    else if (d_req_valid)                 gnt = SRC_D;
  end

  assign gnt_vld       = (gnt == SRC_I) ? if_req_valid : d_req_valid;
  assign mem_req_valid = rstn && gnt_vld && !fifo_full;
  assign if_req_ready  = rstn && (gnt == SRC_I) && mem_req_ready && !fifo_full;
  assign d_req_ready   = rstn && (gnt == SRC_D) && mem_req_ready && !fifo_full;
  assign req_hs        = mem_req_valid && mem_req_ready;

  always_comb begin
    req_mux = '0;
    if (gnt == SRC_I) begin
      req_mux.addr = if_req_addr;
      req_mux.be   = '1;
    end else begin
      req_mux.addr  = d_req_addr;
      req_mux.we    = d_req_we;
      req_mux.be    = d_req_be;
      req_mux.wdata = d_req_wdata;
    end
  end

  assign mem_req_addr  = req_mux.addr;
  assign mem_req_we    = req_mux.we;
  assign mem_req_be    = req_mux.be;
  assign mem_req_wdata = req_mux.wdata;

  always_comb begin
    lock_d     = mem_req_valid && !mem_req_ready;
    lock_src_d = gnt;
    rr_d       = req_hs ? gnt : rr_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lock_q     <= 1'b0;
      lock_src_q <= SRC_I;
      rr_q       <= SRC_D;
    end else begin
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      rr_q       <= rr_d;
    end
  end

  // Stale heads are swallowed here so downstream never stalls on a flushed fetch.
  always_comb begin
    if_rsp_valid  = 1'b0;
    d_rsp_valid   = 1'b0;
    mem_rsp_ready = 1'b0;
    if (!fifo_empty) begin
      if (head_stale) begin
        mem_rsp_ready = 1'b1;
      end else if (head_src == SRC_I) begin
        if_rsp_valid  = mem_rsp_valid;
        mem_rsp_ready = if_rsp_ready;
      end else begin
        d_rsp_valid   = mem_rsp_valid;
        mem_rsp_ready = d_rsp_ready;
      end
    end
  end

  assign if_rsp_data = mem_rsp_data[31:0];
  assign d_rsp_data  = mem_rsp_data;
  assign rsp_hs      = mem_rsp_valid && mem_rsp_ready;

  arb_route_fifo #(.DEPTH(MAX_OUTST)) u_route (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (req_hs),
    .push_src_i  (gnt),
    .pop_i       (rsp_hs),
    .mark_stale_i(flush),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_src_o  (head_src),
    .head_stale_o(head_stale)
  );

`ifndef SYNTHESIS
  a_lock_hold: assert property (@(posedge clk) disable iff (!rstn)
    lock_q |-> ((lock_src_q == SRC_I) ? if_req_valid : d_req_valid));
  a_rsp_when_empty: assert property (@(posedge clk) disable iff (!rstn)
    mem_rsp_valid |-> !fifo_empty);
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter: expected requests/responses queued by stimulus, checked by monitors.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic            clk = 1'b0;
  logic            rstn;
  logic            if_flush;
  logic            if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready;
  logic [XLEN-1:0] if_req_addr;
  logic [31:0]     if_rsp_data;
  logic            d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_ready;
  logic [XLEN-1:0] d_req_addr;
  logic [7:0]      d_req_be;
  logic [63:0]     d_req_wdata, d_rsp_data;
  logic            mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid, mem_rsp_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic [7:0]      mem_req_be;
  logic [63:0]     mem_req_wdata, mem_rsp_data;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_OUTST(4), .DATA_W(64)) dut (
    .clk(clk), .rstn(rstn),
`ifdef FETCH_FLUSH_EN
    .if_flush(if_flush),
`endif
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_data(if_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_be(d_req_be), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_be(mem_req_be), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data)
  );

  typedef struct {
    bit          is_i;
    logic [31:0] addr;
    bit          we;
    logic [7:0]  be;
    logic [63:0] wdata;
  } req_exp_t;

  typedef struct {
    bit          is_i;
    bit          chk;
    logic [63:0] data;
  } rsp_exp_t;

  req_exp_t rq[$];
  rsp_exp_t sq[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  function automatic logic [63:0] beat(int k);
    return {32'hD0D0_D000 + 32'(k), 32'h0000_00A0 + 32'(k)};
  endfunction

  // Request monitor
  always @(negedge clk) begin
    if (rstn && mem_req_valid && mem_req_ready) begin
      if (rq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_req: got addr %h, expected no request", mem_req_addr);
      end else begin
        req_exp_t e;
        e = rq.pop_front();
        chk("req_if_ready", if_req_ready, e.is_i);
        chk("req_d_ready", d_req_ready, !e.is_i);
        chk("req_addr", mem_req_addr, e.addr);
        chk("req_we", mem_req_we, e.we);
        chk("req_be", mem_req_be, e.be);
        chk("req_wdata", mem_req_wdata, e.wdata);
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (rstn && if_rsp_valid && if_rsp_ready) begin
      if (sq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_if_rsp: got %h, expected no response", if_rsp_data);
      end else begin
        rsp_exp_t e;
        e = sq.pop_front();
        chk("if_rsp_owner", 1'b1, e.is_i);
        chk("if_rsp_data", if_rsp_data, e.data[31:0]);
      end
    end
    if (rstn && d_rsp_valid && d_rsp_ready) begin
      if (sq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_d_rsp: got %h, expected no response", d_rsp_data);
      end else begin
        rsp_exp_t e;
        e = sq.pop_front();
        chk("d_rsp_owner", 1'b0, e.is_i);
        if (e.chk) chk("d_rsp_data", d_rsp_data, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    if_flush = 0; if_req_valid = 0; if_req_addr = '0; if_rsp_ready = 1;
    d_req_valid = 0; d_req_addr = '0; d_req_we = 0; d_req_be = '0; d_req_wdata = '0; d_rsp_ready = 1;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0;
  endtask

  task automatic do_reset();
    idle();
    rstn = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int ni, nd;
    idle();
    rstn = 0;
    // Reset: drive everything active, all handshake outputs must stay low
    if_req_valid = 1; d_req_valid = 1; mem_req_ready = 1; mem_rsp_valid = 1;
    @(negedge clk);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_if_req_ready", if_req_ready, 0);
    chk("rst_d_req_ready", d_req_ready, 0);
    chk("rst_mem_rsp_ready", mem_rsp_ready, 0);
    chk("rst_if_rsp_valid", if_rsp_valid, 0);
    chk("rst_d_rsp_valid", d_rsp_valid, 0);
    idle();
    @(posedge clk); #1 rstn = 1;

    // Single fetch
    rq.push_back('{1'b1, 32'h8000_0000, 1'b0, 8'hFF, 64'h0});
    sq.push_back('{1'b1, 1'b1, 64'h13});
    if_req_valid = 1; if_req_addr = 32'h8000_0000; mem_req_ready = 1;
    step();
    if_req_valid = 0; mem_rsp_valid = 1; mem_rsp_data = 64'h13;
    @(negedge clk);
    chk("t1_d_rsp_valid", d_rsp_valid, 0);
    chk("t1_if_rsp_valid", if_rsp_valid, 1);
    step();
    mem_rsp_valid = 0;

    // Both valid for 8 cycles: I,D,I,D... with in-order responses
    do_reset();
    mem_req_ready = 1;
    ni = 0; nd = 0;
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin
        if_req_valid = 1; if_req_addr = 32'h1000 + 32'(4 * ni);
        d_req_valid = 1; d_req_addr = 32'h2000 + 32'(8 * nd);
        d_req_we = 0; d_req_be = 8'h0F; d_req_wdata = 64'h5555_0000 + 64'(nd);
        if (k % 2 == 0) begin
          rq.push_back('{1'b1, 32'h1000 + 32'(4 * ni), 1'b0, 8'hFF, 64'h0});
          sq.push_back('{1'b1, 1'b1, beat(k)});
        end else begin
          rq.push_back('{1'b0, 32'h2000 + 32'(8 * nd), 1'b0, 8'h0F, 64'h5555_0000 + 64'(nd)});
          sq.push_back('{1'b0, 1'b1, beat(k)});
        end
      end else begin
        if_req_valid = 0; d_req_valid = 0;
      end
      mem_rsp_valid = (k >= 1);
      mem_rsp_data  = (k >= 1) ? beat(k - 1) : 64'h0;
      step();
      if (k % 2 == 0) ni++; else nd++;
    end
    mem_rsp_valid = 0;

    // Stalled store keeps grant and stable fields while fetch rises
    do_reset();
    rq.push_back('{1'b0, 32'h100, 1'b1, 8'hFF, 64'hDEAD});
    rq.push_back('{1'b1, 32'h8000_0040, 1'b0, 8'hFF, 64'h0});
    sq.push_back('{1'b0, 1'b0, 64'h0});
    sq.push_back('{1'b1, 1'b1, 64'h297});
    d_req_valid = 1; d_req_we = 1; d_req_addr = 32'h100; d_req_be = 8'hFF; d_req_wdata = 64'hDEAD;
    for (int s = 0; s < 3; s++) begin
      if (s == 1) begin if_req_valid = 1; if_req_addr = 32'h8000_0040; end
      @(negedge clk);
      chk("t3_stall_valid", mem_req_valid, 1);
      chk("t3_stall_addr", mem_req_addr, 32'h100);
      chk("t3_stall_we", mem_req_we, 1);
      chk("t3_stall_wdata", mem_req_wdata, 64'hDEAD);
      step();
    end
    mem_req_ready = 1;
    step();
    d_req_valid = 0;
    step();
    if_req_valid = 0; mem_req_ready = 0;
    mem_rsp_valid = 1; mem_rsp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    mem_rsp_data = 64'h297;
    step();
    mem_rsp_valid = 0;

    // Four outstanding fill the FIFO; fifth waits for a drain
    do_reset();
    mem_req_ready = 1;
    d_req_valid = 1; d_req_we = 0; d_req_be = 8'hFF;
    for (int j = 0; j < 4; j++) begin
      d_req_addr = 32'h3000 + 32'(8 * j);
      rq.push_back('{1'b0, 32'h3000 + 32'(8 * j), 1'b0, 8'hFF, 64'h0});
      sq.push_back('{1'b0, 1'b1, 64'hC0 + 64'(j)});
      step();
    end
    d_req_addr = 32'h3020;
    rq.push_back('{1'b0, 32'h3020, 1'b0, 8'hFF, 64'h0});
    sq.push_back('{1'b0, 1'b1, 64'hC4});
    @(negedge clk);
    chk("t4_full_d_ready", d_req_ready, 0);
    chk("t4_full_req_valid", mem_req_valid, 0);
    step();
    chk("t4_still_blocked", rq.size(), 1);
    mem_rsp_valid = 1; mem_rsp_data = 64'hC0;
    step();
    mem_rsp_valid = 0;
    for (int w = 0; w < 4 && rq.size() != 0; w++) step();
    chk("t4_fifth_issued", rq.size(), 0);
    d_req_valid = 0;
    for (int j = 1; j <= 4; j++) begin
      mem_rsp_valid = 1; mem_rsp_data = 64'hC0 + 64'(j);
      step();
    end
    mem_rsp_valid = 0;

    // Fetch backpressure with an I head
    do_reset();
    mem_req_ready = 1;
    rq.push_back('{1'b1, 32'h8000_0080, 1'b0, 8'hFF, 64'h0});
    sq.push_back('{1'b1, 1'b1, 64'h1111_1111});
    rq.push_back('{1'b0, 32'h400, 1'b0, 8'hFF, 64'h0});
    sq.push_back('{1'b0, 1'b1, 64'h2222_2222_2222_2222});
    if_req_valid = 1; if_req_addr = 32'h8000_0080;
    step();
    if_req_valid = 0; d_req_valid = 1; d_req_addr = 32'h400; d_req_be = 8'hFF;
    step();
    d_req_valid = 0; mem_req_ready = 0;
    if_rsp_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 64'h9999_9999_1111_1111;
    @(negedge clk);
    chk("t5_bp_mem_rsp_ready", mem_rsp_ready, 0);
    chk("t5_bp_if_rsp_valid", if_rsp_valid, 1);
    chk("t5_bp_d_rsp_valid", d_rsp_valid, 0);
    step();
    @(negedge clk);
    chk("t5_bp_hold", mem_rsp_ready, 0);
    step();
    if_rsp_ready = 1;
    @(negedge clk);
    chk("t5_release", mem_rsp_ready, 1);
    step();
    mem_rsp_data = 64'h2222_2222_2222_2222;
    step();
    mem_rsp_valid = 0;

`ifdef FETCH_FLUSH_EN
    // Flush drops the two older fetch responses, not the one issued with the flush
    do_reset();
    mem_req_ready = 1;
    rq.push_back('{1'b1, 32'h8000_0000, 1'b0, 8'hFF, 64'h0});
    rq.push_back('{1'b1, 32'h8000_0004, 1'b0, 8'hFF, 64'h0});
    rq.push_back('{1'b1, 32'h8000_0010, 1'b0, 8'hFF, 64'h0});
    sq.push_back('{1'b1, 1'b1, 64'h33});
    if_req_valid = 1; if_req_addr = 32'h8000_0000;
    step();
    if_req_addr = 32'h8000_0004;
    step();
    if_req_addr = 32'h8000_0010; if_flush = 1;
    step();
    if_req_valid = 0; if_flush = 0; mem_req_ready = 0;
    if_rsp_ready = 0;
    for (int s = 0; s < 2; s++) begin
      mem_rsp_valid = 1; mem_rsp_data = 64'hAAAA + 64'(s);
      @(negedge clk);
      chk("t6_stale_accept", mem_rsp_ready, 1);
      chk("t6_stale_no_valid", if_rsp_valid, 0);
      step();
    end
    if_rsp_ready = 1; mem_rsp_data = 64'h33;
    step();
    mem_rsp_valid = 0;
`endif

    step(); step();
    chk("end_req_q_empty", rq.size(), 0);
    chk("end_rsp_q_empty", sq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
